tdm_mux_8x1: RTL and testbench
==============================

Name: tdm_mux_8x1

Overview:
- Time-division 8:1 multiplexer: the transmit end of the 1x8 demux channel path.
- Snapshots eight 1-bit channel inputs and serialises them onto one line, slot 0 to slot 7.
- Drives the slot index on `sel` so a downstream demux_1x8 can route each bit back to its own y0..y7.
- Sits between the channel sources and the shared serial line / demux_1x8 receiver.

Parameters:
- DWELL, default 1: clock cycles each slot is held. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- cont  input  1  continuous mode; when 1 at frame end, the next frame starts without returning to IDLE.
- en  input  1  advance enable; 0 stalls the scan in place.
- i0..i7  input  1 each  channel inputs.
- out  output  1  serial data, equal to the snapshot bit of the current slot.
- sel  output  3  current slot index, 0..7.
- frame_start  output  1  high during the first cycle of slot 0 of every frame.
- frame_done  output  1  one-cycle pulse after the last cycle of slot 7.
- busy  output  1  high in SCAN.

Behaviour:

Reset (asynchronous, any time, including mid-frame):
- state=IDLE, snapshot=8'h00, sel=0, dwell_cnt=0.
- out=0, frame_start=0, frame_done=0, busy=0.

States: IDLE, SCAN.

IDLE:
- Outputs out=0, sel=0, busy=0.
- On an edge with start=1:
  - snapshot <= {i7..i0}
  - sel <= 0, dwell_cnt <= 0
  - state <= SCAN
  - frame_start <= 1
- en is ignored for this transition.
- start=0: remain in IDLE.

SCAN:
- busy=1.
- out = snapshot[sel], decoded from registers; no extra latency after sel.
- Edges with en=0: all state holds (sel, dwell_cnt, snapshot, out, frame_start held); frame_done forced 0.
- Edges with en=1 and dwell_cnt < DWELL-1: dwell_cnt increments; frame_start <= 0.
- Edges with en=1 and dwell_cnt == DWELL-1:
  - dwell_cnt <= 0
  - if sel < 7: sel <= sel+1, frame_start <= 0
  - if sel == 7: frame_done <= 1 for exactly one cycle, then:
    - cont=1: snapshot <= {i7..i0}, sel <= 0, frame_start <= 1, stay in SCAN (back-to-back frames, no gap cycle).
    - cont=0: state <= IDLE, sel <= 0, frame_start <= 0.

Timing:
- Latency: first slot-0 bit appears on out in the cycle after the start edge.
- Frame length: 8*DWELL cycles when en is held high.

Boundary rules:
- start in SCAN: ignored; no restart.
- Inputs change mid-frame: no effect until the next snapshot.
- cont dropped mid-frame: current frame completes, then IDLE.
- start and cont both 1 in IDLE: starts in continuous mode.
- en=0 during the frame_done edge: the wrap is deferred until en=1.
- Async reset during slot 3: all outputs go to reset values immediately, without waiting for clk.

Widths:
- dwell_cnt is 8 bits.
- sel wraps 7 to 0 only via the frame-end path, never by overflow.

Test Plan:
1. DWELL=1, cont=0, i7..i0=8'b1010_0110, start pulse:
   - sel steps 0..7 on consecutive cycles.
   - out sequence = 0,1,1,0,0,1,0,1.
   - frame_start high on the slot 0 cycle only.
   - frame_done pulses once, then IDLE with out=0, busy=0.
2. DWELL=3, inputs 8'hFF:
   - each sel value is held 3 cycles; out=1 throughout.
   - busy high for 24 cycles.
3. cont=1, first snapshot 8'h0F, i changed to 8'hF0 during slot 4:
   - frame 1 out = 1,1,1,1,0,0,0,0.
   - frame 2 starts with no gap; out = 0,0,0,0,1,1,1,1.
   - frame_start high at both slot 0 cycles.
4. Stall: en=0 for 5 cycles at sel=2:
   - sel, out and dwell_cnt hold.
   - the frame completes 5 cycles late with the correct bits.
5. start asserted again at sel=5 in SCAN: ignored; the frame ends normally at sel=7.
6. Async rst asserted mid-edge-interval at sel=3:
   - out=0, sel=0, busy=0 before the next clk edge.
   - after release, a start pulse produces a clean frame.

Source files
------------

// File: rtl/tdm_mux_8x1.sv
// Time-division 8:1 multiplexer: snapshots eight channel bits and serialises
// them slot 0..7 onto `out`, publishing the slot index on `sel` for a demux_1x8.
module tdm_mux_8x1 #(
  parameter int DWELL = 1  // cycles per slot, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       en,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  output logic       out,
  output logic [2:0] sel,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

  state_t     state, state_nxt;
  logic [7:0] snap, snap_nxt;
  logic [7:0] dwell_cnt, cnt_nxt;
  logic [2:0] sel_nxt;
  logic       fs_nxt, fd_nxt;
  logic [7:0] chans;

  assign chans = {i7, i6, i5, i4, i3, i2, i1, i0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= 8'h00;
      dwell_cnt   <= 8'h00;
      sel         <= 3'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      snap        <= snap_nxt;
      dwell_cnt   <= cnt_nxt;
      sel         <= sel_nxt;
      frame_start <= fs_nxt;
      frame_done  <= fd_nxt;
    end
  end

  // With en=0 every register keeps its value except frame_done, which drops.
  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    cnt_nxt   = dwell_cnt;
    sel_nxt   = sel;
    fs_nxt    = frame_start;
    fd_nxt    = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = 3'd0;
        cnt_nxt = 8'h00;
        fs_nxt  = 1'b0;
        if (start) begin
          snap_nxt  = chans;
          state_nxt = SCAN;
          fs_nxt    = 1'b1;
        end
      end
      SCAN: begin
        if (en) begin
          if (dwell_cnt != LAST_CNT) begin
            cnt_nxt = dwell_cnt + 8'd1;
            fs_nxt  = 1'b0;
          end else begin
            cnt_nxt = 8'h00;
            if (sel != 3'd7) begin
              sel_nxt = sel + 3'd1;
              fs_nxt  = 1'b0;
            end else begin
              // Frame end: continuous mode re-snapshots with no gap cycle.
              fd_nxt  = 1'b1;
              sel_nxt = 3'd0;
              if (cont) begin
                snap_nxt = chans;
                fs_nxt   = 1'b1;
              end else begin
                state_nxt = IDLE;
                fs_nxt    = 1'b0;
              end
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);
  assign out  = busy & snap[sel];

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Directed bench for tdm_mux_8x1: a DWELL=1 instance carries most scenarios,
// a DWELL=3 instance covers slot dwell and frame length.
module tb_tdm_mux_8x1;

  logic       clk = 1'b0;
  logic       rst, start, cont, en, start3;
  logic [7:0] ch, ch3;
  logic       out1, fs1, fd1, busy1;
  logic [2:0] sel1;
  logic       out3, fs3, fd3, busy3;
  logic [2:0] sel3;

  int checks = 0;
  int errors = 0;
  int busy_cycles;
  logic [7:0] exp_bits;

  always #5 clk = ~clk;

  tdm_mux_8x1 #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .en(en),
    .i0(ch[0]), .i1(ch[1]), .i2(ch[2]), .i3(ch[3]),
    .i4(ch[4]), .i5(ch[5]), .i6(ch[6]), .i7(ch[7]),
    .out(out1), .sel(sel1), .frame_start(fs1), .frame_done(fd1), .busy(busy1)
  );

  tdm_mux_8x1 #(.DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cont(cont), .en(en),
    .i0(ch3[0]), .i1(ch3[1]), .i2(ch3[2]), .i3(ch3[3]),
    .i4(ch3[4]), .i5(ch3[5]), .i6(ch3[6]), .i7(ch3[7]),
    .out(out3), .sel(sel3), .frame_start(fs3), .frame_done(fd3), .busy(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares {sel,out,frame_start,frame_done,busy} of the DWELL=1 instance.
  task automatic chk(input string tag, input int s, input bit o, input bit f,
                     input bit d, input bit b);
    logic [6:0] obs, exp;
    obs = {sel1, out1, fs1, fd1, busy1};
    exp = {3'(s), o, f, d, b};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sel/out/fs/fd/busy=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; en = 1'b1;
    start3 = 1'b0; ch = 8'h00; ch3 = 8'h00;
    #12;
    chk("reset", 0, 0, 0, 0, 0);
    chkv("reset_dut3", {sel3, out3, fs3, fd3, busy3}, 8'h00);
    rst = 1'b0;

    // 1: single frame, DWELL=1, inputs 1010_0110
    exp_bits = 8'b1010_0110;
    ch = 8'hA6; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_slot%0d", k), k, exp_bits[k], k == 0, 0, 1);
      step();
    end
    chk("t1_done", 0, 0, 0, 1, 0);
    step();
    chk("t1_idle", 0, 0, 0, 0, 0);

    // 2: DWELL=3, all ones
    ch3 = 8'hFF; start3 = 1'b1;
    step();
    start3 = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy3) begin
        busy_cycles++;
        chkv($sformatf("t2_sel_c%0d", c), {5'd0, sel3}, 8'(c / 3));
        chkv($sformatf("t2_out_c%0d", c), {7'd0, out3}, 8'd1);
      end
      if (c == 24) chkv("t2_done", {6'd0, fd3, busy3}, 8'b10);
      step();
    end
    chkv("t2_busy_cycles", 8'(busy_cycles), 8'd24);

    // 3: continuous, 0F then F0 captured at the wrap; cont dropped in frame 2
    cont = 1'b1; ch = 8'h0F; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3a_slot%0d", k), k, k < 4, k == 0, 0, 1);
      if (k == 4) ch = 8'hF0;
      step();
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3b_slot%0d", k), k, k >= 4, k == 0, k == 0, 1);
      if (k == 2) cont = 1'b0;
      step();
    end
    chk("t3_done", 0, 0, 0, 1, 0);
    step();

    // 4: stalls at slot 0, 5 cycles at slot 2, and across the frame-end edge
    exp_bits = 8'b0101_1100;
    ch = 8'h5C; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_slot0", 0, 0, 1, 0, 1);
    en = 1'b0;
    step();
    chk("t4_hold0", 0, 0, 1, 0, 1);
    en = 1'b1;
    step();
    chk("t4_slot1", 1, 0, 0, 0, 1);
    step();
    chk("t4_slot2", 2, 1, 0, 0, 1);
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("t4_stall%0d", j), 2, 1, 0, 0, 1);
    end
    en = 1'b1;
    step();
    for (int k = 3; k < 8; k++) begin
      chk($sformatf("t4_slot%0d", k), k, exp_bits[k], 0, 0, 1);
      if (k < 7) step();
    end
    en = 1'b0;
    step();
    chk("t4_defer", 7, 0, 0, 0, 1);
    en = 1'b1;
    step();
    chk("t4_done", 0, 0, 0, 1, 0);
    step();

    // 5: start re-asserted at slot 5 is ignored
    exp_bits = 8'b0011_1100;
    ch = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t5_slot%0d", k), k, exp_bits[k], k == 0, 0, 1);
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      step();
    end
    chk("t5_done", 0, 0, 0, 1, 0);
    step();
    chk("t5_idle", 0, 0, 0, 0, 0);

    // 6: asynchronous reset in slot 3, then a clean frame
    ch = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("t6_slot3", 3, 1, 0, 0, 1);
    #2 rst = 1'b1;
    #1 chk("t6_async", 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    step();
    chk("t6_idle", 0, 0, 0, 0, 0);
    exp_bits = 8'b1000_0001;
    ch = 8'h81; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t6_slot%0d", k), k, exp_bits[k], k == 0, 0, 1);
      step();
    end
    chk("t6_done", 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
